// File: rtl/lblock_ctrl.sv
// lblock_ctrl: job sequencer driving the iterative LBlock round core.
// Optional abort port pair is built when LBLOCK_CTRL_ABORT_EN is defined.
module lblock_ctrl #(
  parameter int ROUNDS = 32,
  parameter int CNT_W  = 16
) (
  input  logic             ACLK,
  input  logic             ARESETN,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_decrypt,
  input  logic [79:0]      cmd_key,
  input  logic [63:0]      cmd_block,
  output logic             core_load,
  output logic [79:0]      core_key,
  output logic [63:0]      core_block,
  output logic             core_decrypt,
  output logic             core_key_step,
  output logic             core_round_en,
  output logic [4:0]       core_round_idx,
  input  logic [63:0]      core_result,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [63:0]      res_data,
  output logic             busy,
  output logic [CNT_W-1:0] done_cnt
`ifdef LBLOCK_CTRL_ABORT_EN
  ,
  input  logic             abort,
  output logic             aborted
`endif
);

  localparam logic [4:0] LAST = 5'(ROUNDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_KWIND,
    S_ROUND,
    S_CAP,
    S_OUT
  } state_e;

  state_e           state_q, state_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [79:0]      key_q, key_d;
  logic [63:0]      blk_q, blk_d;
  logic             dec_q, dec_d;
  logic [63:0]      res_q, res_d;
  logic [CNT_W-1:0] done_q, done_d;
  logic             rdy_c;

  // State and datapath registers.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      key_q   <= '0;
      blk_q   <= '0;
      dec_q   <= 1'b0;
      res_q   <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      blk_q   <= blk_d;
      dec_q   <= dec_d;
      res_q   <= res_d;
      done_q  <= done_d;
    end
  end

  // Next state, phase counter and core strobes.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    key_d          = key_q;
    blk_d          = blk_q;
    dec_d          = dec_q;
    res_d          = res_q;
    done_d         = done_q;
    rdy_c          = 1'b0;
    core_load      = 1'b0;
    core_key_step  = 1'b0;
    core_round_en  = 1'b0;
    core_round_idx = 5'd0;
    res_valid      = 1'b0;
`ifdef LBLOCK_CTRL_ABORT_EN
    aborted        = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        rdy_c = 1'b1;
        if (cmd_valid) begin
          key_d   = cmd_key;
          blk_d   = cmd_block;
          dec_d   = cmd_decrypt;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        core_load = 1'b1;
        cnt_d     = 5'd0;
        state_d   = dec_q ? S_KWIND : S_ROUND;
      end
      S_KWIND: begin
        core_key_step = 1'b1;
        if (cnt_q == LAST) begin
          cnt_d   = 5'd0;
          state_d = S_ROUND;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      S_ROUND: begin
        core_round_en  = 1'b1;
        core_round_idx = dec_q ? (LAST - cnt_q) : cnt_q;
        if (cnt_q == LAST) begin
          cnt_d   = 5'd0;
          state_d = S_CAP;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      S_CAP: begin
        res_d   = core_result;
        state_d = S_OUT;
      end
      S_OUT: begin
        res_valid = 1'b1;
        rdy_c     = res_ready;
        if (res_ready) begin
          done_d = done_q + CNT_W'(1);
          if (cmd_valid) begin
            key_d   = cmd_key;
            blk_d   = cmd_block;
            dec_d   = cmd_decrypt;
            state_d = S_LOAD;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
`ifdef LBLOCK_CTRL_ABORT_EN
    if (abort && (state_q inside {S_LOAD, S_KWIND, S_ROUND, S_CAP})) begin
      aborted = 1'b1;
      state_d = S_IDLE;
      cnt_d   = 5'd0;
      res_d   = res_q;
    end
`endif
  end

  assign cmd_ready    = rdy_c & ARESETN;
  assign core_key     = key_q;
  assign core_block   = blk_q;
  assign core_decrypt = dec_q;
  assign res_data     = res_q;
  assign busy         = (state_q != S_IDLE);
  assign done_cnt     = done_q;

endmodule

// File: tb/tb_lblock_ctrl.sv
// tb_lblock_ctrl: vectors + random jobs against a toy invertible core.
// Abort sequence is built when LBLOCK_CTRL_ABORT_EN is defined.
module tb_lblock_ctrl;
  localparam int R = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        cmd_valid = 0, cmd_decrypt = 0, res_ready = 0;
  logic [79:0] cmd_key = '0;
  logic [63:0] cmd_block = '0;
  logic        cmd_ready, core_load, core_decrypt;
  logic        core_key_step, core_round_en, res_valid, busy;
  logic [79:0] core_key;
  logic [63:0] core_block, core_result, res_data;
  logic [4:0]  core_round_idx;
  logic [15:0] done_cnt;
  logic        abort = 0, aborted;

  logic        w_cmd_valid = 0, w_res_ready = 0;
  logic        w_cmd_ready, w_load, w_dec, w_kstep, w_ren;
  logic        w_res_valid, w_busy, w_aborted;
  logic [79:0] w_key;
  logic [63:0] w_blk, w_res;
  logic [4:0]  w_idx;
  logic [1:0]  w_done;

  lblock_ctrl #(.ROUNDS(R), .CNT_W(16)) dut (
    .ACLK(clk), .ARESETN(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_decrypt(cmd_decrypt), .cmd_key(cmd_key),
    .cmd_block(cmd_block), .core_load(core_load),
    .core_key(core_key), .core_block(core_block),
    .core_decrypt(core_decrypt), .core_key_step(core_key_step),
    .core_round_en(core_round_en), .core_round_idx(core_round_idx),
    .core_result(core_result), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data),
    .busy(busy), .done_cnt(done_cnt)
`ifdef LBLOCK_CTRL_ABORT_EN
    , .abort(abort), .aborted(aborted)
`endif
  );

  lblock_ctrl #(.ROUNDS(2), .CNT_W(2)) dut_w (
    .ACLK(clk), .ARESETN(rst_n),
    .cmd_valid(w_cmd_valid), .cmd_ready(w_cmd_ready),
    .cmd_decrypt(1'b0), .cmd_key(80'h0),
    .cmd_block(64'h0), .core_load(w_load),
    .core_key(w_key), .core_block(w_blk),
    .core_decrypt(w_dec), .core_key_step(w_kstep),
    .core_round_en(w_ren), .core_round_idx(w_idx),
    .core_result(64'h0), .res_valid(w_res_valid),
    .res_ready(w_res_ready), .res_data(w_res),
    .busy(w_busy), .done_cnt(w_done)
`ifdef LBLOCK_CTRL_ABORT_EN
    , .abort(1'b0), .aborted(w_aborted)
`endif
  );

`ifndef LBLOCK_CTRL_ABORT_EN
  assign aborted   = 1'b0;
  assign w_aborted = 1'b0;
`endif

  // Toy invertible core: key rotates 13 per round, data rotate-add-xor.
  function automatic logic [79:0] rotl80(input logic [79:0] k);
    return {k[66:0], k[79:67]};
  endfunction
  function automatic logic [79:0] rotr80(input logic [79:0] k);
    return {k[12:0], k[79:13]};
  endfunction
  function automatic logic [63:0] enc_rnd(input logic [63:0] d,
      input logic [79:0] k, input logic [4:0] i);
    return ({d[58:0], d[63:59]} + k[63:0]) ^ {59'b0, i};
  endfunction
  function automatic logic [63:0] dec_rnd(input logic [63:0] d,
      input logic [79:0] k, input logic [4:0] i);
    logic [63:0] t;
    t = (d ^ {59'b0, i}) - k[63:0];
    return {t[4:0], t[63:5]};
  endfunction

  logic [63:0] cd = '0;
  logic [79:0] ck = '0;
  assign core_result = cd;
  always @(posedge clk) begin
    if (core_load) begin
      cd <= core_block;
      ck <= core_key;
    end else if (core_key_step) begin
      ck <= rotl80(ck);
    end else if (core_round_en) begin
      if (!core_decrypt) begin
        cd <= enc_rnd(cd, ck, core_round_idx);
        ck <= rotl80(ck);
      end else begin
        cd <= dec_rnd(cd, rotr80(ck), core_round_idx);
        ck <= rotr80(ck);
      end
    end
  end

  // Reference: whole-job cipher computed straight from the key schedule.
  function automatic logic [63:0] toy_enc(input logic [79:0] k,
      input logic [63:0] b);
    for (int i = 0; i < R; i++) begin
      b = enc_rnd(b, k, 5'(i));
      k = rotl80(k);
    end
    return b;
  endfunction
  function automatic logic [63:0] toy_dec(input logic [79:0] k,
      input logic [63:0] b);
    logic [79:0] ks [R];
    for (int i = 0; i < R; i++) begin
      ks[i] = k;
      k = rotl80(k);
    end
    for (int i = R - 1; i >= 0; i--) b = dec_rnd(b, ks[i], 5'(i));
    return b;
  endfunction

  int n_pass = 0, n_tot = 0;
  int exp_done = 0;

  task automatic check(input string nm, input logic [79:0] act,
      input logic [79:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic issue(input bit dec, input logic [79:0] k,
      input logic [63:0] b);
    int t = 0;
    @(negedge clk);
    cmd_valid = 1; cmd_decrypt = dec; cmd_key = k; cmd_block = b;
    while (!cmd_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("cmd_ready_at_issue", 80'(cmd_ready), 80'd1);
    @(posedge clk);
    #1 cmd_valid = 0;
  endtask

  // Watches one job from the cycle after its cmd handshake.
  task automatic monitor(input bit dec, input logic [63:0] exp);
    int n = 0, loads = 0, ks = 0, rs = 0;
    bit got = 0, seq = 1, excl = 1;
    int lat = dec ? 2 * R + 2 : R + 2;
    while (n <= 200 && !got) begin
      @(negedge clk);
      if (res_valid) begin
        got = 1;
      end else begin
        if (int'(core_load) + int'(core_key_step) + int'(core_round_en) > 1)
          excl = 0;
        if (core_load && n != 0) seq = 0;
        if (core_key_step && rs != 0) seq = 0;
        if (core_round_en) begin
          if (int'(core_round_idx) != (dec ? R - 1 - rs : rs)) seq = 0;
          rs++;
        end else if (core_round_idx != 0) seq = 0;
        loads += int'(core_load);
        ks += int'(core_key_step);
        n++;
      end
    end
    check("res_valid_seen", 80'(got), 80'd1);
    check("latency", 80'(n), 80'(lat));
    check("load_cycles", 80'(loads), 80'd1);
    check("keystep_cycles", 80'(ks), 80'(dec ? R : 0));
    check("round_cycles", 80'(rs), 80'(R));
    check("idx_order", 80'(seq), 80'd1);
    check("strobe_excl", 80'(excl), 80'd1);
    check("res_data", 80'(res_data), 80'(exp));
  endtask

  typedef struct {
    bit          dec;
    logic [79:0] key;
    logic [63:0] blk;
    logic [63:0] exp;
  } vec_t;

  vec_t tv [8];

  initial begin
    logic [79:0] k1;
    logic [63:0] p1, hold;
    bit ok, found;
    int t, last;
    k1 = 80'h0123456789ABCDEFFEDC;
    p1 = 64'h0011_2233_4455_6677;
    tv[0] = '{0, 80'h0, 64'h0, toy_enc(80'h0, 64'h0)};
    tv[1] = '{0, k1, p1, toy_enc(k1, p1)};
    tv[2] = '{1, k1, toy_enc(k1, p1), p1};
    for (int i = 3; i < 8; i++) begin
      tv[i].dec = 1'($urandom);
      tv[i].key = {16'($urandom), $urandom, $urandom};
      tv[i].blk = {$urandom, $urandom};
      tv[i].exp = tv[i].dec ? toy_dec(tv[i].key, tv[i].blk)
                            : toy_enc(tv[i].key, tv[i].blk);
    end

    #2;
    check("rst_outs", 80'({cmd_ready, core_load, core_key_step,
      core_round_en, core_round_idx, res_valid, busy, core_decrypt}), 80'd0);
    check("rst_cnt", 80'({done_cnt, w_done}), 80'd0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check("idle_ready", 80'({cmd_ready, busy}), 80'b10);

    res_ready = 1;
    for (int i = 0; i < 8; i++) begin
      issue(tv[i].dec, tv[i].key, tv[i].blk);
      monitor(tv[i].dec, tv[i].exp);
      @(negedge clk);
      exp_done++;
      check("done_cnt", 80'(done_cnt), 80'(exp_done));
    end

    issue(0, k1, p1);
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (core_round_en && core_round_idx == 5'd10) found = 1;
    end
    check("reach_round10", 80'(found), 80'd1);
    rst_n = 0;
    #1;
    check("async_rst_outs", 80'({cmd_ready, core_load, core_key_step,
      core_round_en, core_round_idx, res_valid, busy, core_decrypt}), 80'd0);
    check("async_rst_regs", 80'(core_key | 80'(core_block) |
      80'(res_data) | 80'(done_cnt)), 80'd0);
    exp_done = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    ok = 1;
    repeat (80) begin
      @(negedge clk);
      if (res_valid || !cmd_ready || busy) ok = 0;
    end
    check("no_spurious_after_rst", 80'(ok), 80'd1);

    res_ready = 0;
    issue(0, k1, p1);
    monitor(0, toy_enc(k1, p1));
    hold = res_data;
    cmd_valid = 1; cmd_decrypt = 1; cmd_key = k1; cmd_block = hold;
    ok = 1;
    repeat (10) begin
      @(negedge clk);
      if (!res_valid || cmd_ready || res_data !== hold) ok = 0;
    end
    check("backpressure_hold", 80'(ok), 80'd1);
    res_ready = 1;
    #1;
    check("b2b_ready", 80'(cmd_ready), 80'd1);
    @(posedge clk);
    #1 cmd_valid = 0;
    exp_done++;
    monitor(1, p1);
    check("b2b_done_cnt", 80'(done_cnt), 80'(exp_done));
    @(negedge clk);
    exp_done++;
    check("done_cnt_after_b2b", 80'(done_cnt), 80'(exp_done));

`ifdef LBLOCK_CTRL_ABORT_EN
    issue(0, k1, p1);
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (core_round_en && core_round_idx == 5'd5) found = 1;
    end
    check("reach_round5", 80'(found), 80'd1);
    abort = 1;
    #1;
    check("aborted_pulse", 80'(aborted), 80'd1);
    @(posedge clk);
    #1 abort = 0;
    @(negedge clk);
    check("abort_idle", 80'({aborted, busy, cmd_ready}), 80'b001);
    ok = 1;
    repeat (60) begin
      @(negedge clk);
      if (res_valid || aborted) ok = 0;
    end
    check("abort_no_result", 80'(ok), 80'd1);
    check("abort_done_cnt", 80'(done_cnt), 80'(exp_done));
    issue(tv[1].dec, tv[1].key, tv[1].blk);
    monitor(tv[1].dec, tv[1].exp);
    @(negedge clk);
    exp_done++;
    check("post_abort_done", 80'(done_cnt), 80'(exp_done));
`endif

    w_res_ready = 1;
    w_cmd_valid = 1;
    last = 0;
    t = 0;
    for (int j = 1; j <= 5; j++) begin
      found = 0;
      while (!found && t < 400) begin
        @(negedge clk);
        t++;
        if (w_res_valid) found = 1;
      end
      check("wrap_valid", 80'(found), 80'd1);
      if (j > 1) check("wrap_period", 80'(t - last), 80'd5);
      last = t;
      @(negedge clk);
      t++;
      check("wrap_cnt", 80'(w_done), 80'(j % 4));
    end
    w_cmd_valid = 0;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/lblock_ctrl.md
Name: lblock_ctrl

Overview:
Sequencer between the LBlock AXI4-Lite register bank and the iterative LBlock round core (64-bit block, 80-bit key).
- Accepts one encrypt/decrypt job per command handshake and drives the core through load, optional key-wind and round phases.
- Captures the result and returns it through a valid/ready result port.
- Keeps a completed-job counter for the register bank status word.

Parameters:
ROUNDS, 32, number of cipher rounds per job; legal range 2..32.
CNT_W, 16, width of the completed-job counter.

Ports:
ACLK  in  1  clock; all state updates on the rising edge
ARESETN  in  1  asynchronous active-low reset
cmd_valid  in  1  job request from register bank
cmd_ready  out  1  controller can accept a job
cmd_decrypt  in  1  1 = decrypt, 0 = encrypt; sampled on the cmd handshake
cmd_key  in  80  key; sampled on the cmd handshake
cmd_block  in  64  plaintext or ciphertext; sampled on the cmd handshake
core_load  out  1  one-cycle pulse: core loads core_key and core_block
core_key  out  80  registered key presented to the core
core_block  out  64  registered block presented to the core
core_decrypt  out  1  registered mode
core_key_step  out  1  advance core key register without touching data (key-wind)
core_round_en  out  1  core executes one round this cycle
core_round_idx  out  5  round index for the current round cycle
core_result  in  64  core data register output
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
res_data  out  64  registered result
busy  out  1  high in any state except IDLE
done_cnt  out  CNT_W  count of result handshakes

Behaviour:
- Reset (async, ARESETN=0) clears all outputs and internal registers to 0 and puts the FSM in IDLE. Reset mid-job discards the job; no res_valid follows.
- FSM states:
  - IDLE: cmd_ready=1. cmd_valid&cmd_ready latches key, block and mode into core_key, core_block and core_decrypt, then goes to LOAD.
  - LOAD: core_load=1 for exactly 1 cycle. Next state is KEYWIND if decrypt, otherwise ROUND.
  - KEYWIND: core_key_step=1 for ROUNDS consecutive cycles, counted 0..ROUNDS-1, then ROUND.
  - ROUND: core_round_en=1 for ROUNDS cycles. core_round_idx runs 0..ROUNDS-1 for encrypt and ROUNDS-1..0 for decrypt. Then CAP.
  - CAP: 1 cycle; res_data <= core_result. Then OUT.
  - OUT: res_valid=1 while res_data is held stable. On res_valid&res_ready: done_cnt increments and the FSM returns to IDLE.
- Back-to-back jobs: cmd_ready is also 1 in OUT when res_ready=1. A simultaneous result handshake and command handshake goes directly to LOAD, so there is no IDLE bubble.
- Latency from the cmd handshake edge to first res_valid cycle:
  - encrypt: ROUNDS+2 cycles (34 at default).
  - decrypt: 2*ROUNDS+2 cycles (66 at default).
- Output exclusivity: core_load, core_key_step and core_round_en are mutually exclusive and are 0 outside their states.
- core_round_idx is 0 when not in ROUND.
- done_cnt wraps modulo 2^CNT_W with no saturation.
- cmd_* inputs are ignored when cmd_ready=0. res_valid is never deasserted without a handshake, except on reset or abort.
- Round/key-wind counter width is 5 bits. Terminal condition is count==ROUNDS-1.

Optional Feature:
LBLOCK_CTRL_ABORT_EN
- When defined, adds input abort (1 bit) and output aborted (1 bit, one-cycle pulse).
  - abort=1 in LOAD, KEYWIND, ROUND or CAP: FSM goes to IDLE on the next edge, aborted pulses that cycle, and no res_valid is produced.
  - abort in IDLE or OUT has no effect.
  - done_cnt is unchanged by an abort.
- When undefined, the ports do not exist and jobs always run to completion.

Test Plan:
- Encrypt, default ROUNDS:
  - Stimulus: key=80'h0, block=64'h0, res_ready=1.
  - Required: core_load 1 cycle; 32 round_en cycles with idx 0..31; res_valid exactly 34 cycles after the cmd edge; res_data = core model value; done_cnt=1.
- Decrypt:
  - Stimulus: key=80'h0123456789ABCDEFFEDC, cmd_decrypt=1.
  - Required: 32 key_step cycles, then 32 round cycles with idx 31..0; res_valid at 66 cycles; result equals the original plaintext from a prior encrypt.
- Backpressure and back-to-back:
  - Stimulus: hold res_ready=0 for 10 cycles with cmd_valid held high.
  - Required: res_data is stable and cmd_ready=0 while waiting. Raising res_ready gives a result and command handshake in the same cycle, the next cycle is LOAD, and done_cnt=1.
- Async reset mid-job:
  - Stimulus: ARESETN low for 3 cycles during round 10.
  - Required: all outputs 0 immediately; after release, IDLE with cmd_ready=1 and no spurious res_valid.
- Counter wrap:
  - Stimulus: CNT_W=2, 5 jobs.
  - Required: done_cnt sequence 1,2,3,0,1.
- With LBLOCK_CTRL_ABORT_EN:
  - Stimulus: abort asserted in round 5.
  - Required: aborted pulse of 1 cycle, IDLE next cycle, no res_valid, done_cnt unchanged; a following job completes normally.
